// File: rtl/axil_reg_initiator.sv
// Single-outstanding AXI4-Lite initiator: turns a cmd/rsp handshake into one register
// write or read at a time, with an optional per-transaction timeout abort.
module axil_reg_initiator #(
    parameter int unsigned         ADDR_W  = 32,
    parameter int unsigned         DATA_W  = 32,
    parameter int unsigned         TIMEOUT = 1024,
    parameter logic [DATA_W-1:0]   TO_DATA = DATA_W'(32'hdeaddead)
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n_sync,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic [1:0]          rsp_resp,
    output logic                rsp_timeout,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp
);

    localparam int unsigned     CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdData,
        StRsp
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                active;
    logic                expire;
    logic                abort;

    assign active = (state_q == StWrReq) || (state_q == StWrResp) ||
                    (state_q == StRdReq) || (state_q == StRdData);
    // Count reaching TIMEOUT on this edge aborts, unless the pending handshake lands first.
    assign expire = (TIMEOUT != 0) && (cnt_q >= CntLast);

    assign cmd_ready   = cmd_ready_q;
    assign awvalid     = (state_q == StWrReq) && !aw_done_q;
    assign wvalid      = (state_q == StWrReq) && !w_done_q;
    assign awaddr      = addr_q;
    assign wdata       = wdata_q;
    assign wstrb       = '1;
    assign bready      = (state_q == StWrResp);
    assign arvalid     = (state_q == StRdReq);
    assign araddr      = addr_q;
    assign rready      = (state_q == StRdData);
    assign rsp_valid   = (state_q == StRsp);
    assign rsp_data    = rsp_data_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        cnt_d         = cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        abort         = 1'b0;

        if (active && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = cmd_write ? StWrReq : StRdReq;
                end
            end
            StWrReq: begin
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) begin
                    state_d = StWrResp;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            StWrResp: begin
                if (bvalid) begin
                    rsp_data_d    = '0;
                    rsp_resp_d    = bresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = StRsp;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            StRdReq: begin
                if (arready) begin
                    state_d = StRdData;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            StRdData: begin
                if (rvalid) begin
                    rsp_data_d    = rdata;
                    rsp_resp_d    = rresp;
                    rsp_timeout_d = 1'b0;
                    state_d       = StRsp;
                end else if (expire) begin
                    abort = 1'b1;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d       = StRsp;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_data_d    = ((state_q == StRdReq) || (state_q == StRdData)) ? TO_DATA : '0;
        end

        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_main_a0) begin
        if (!rst_main_n_sync) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wdata_q       <= '0;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cnt_q         <= '0;
            rsp_data_q    <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            cmd_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            cnt_q         <= cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            cmd_ready_q   <= cmd_ready_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_initiator.sv
// Bench for axil_reg_initiator: delay-programmable AXI-Lite slave, a directed vector table,
// reset-in-flight sequence and randomized traffic checked against a timing/memory model.
module tb_axil_reg_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_reg_initiator #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO),
        .TO_DATA(32'hdeaddead)
    ) dut (
        .clk_main_a0    (clk),
        .rst_main_n_sync(rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_resp       (rsp_resp),
        .rsp_timeout    (rsp_timeout),
        .awvalid        (awvalid),
        .awready        (awready),
        .awaddr         (awaddr),
        .wvalid         (wvalid),
        .wready         (wready),
        .wdata          (wdata),
        .wstrb          (wstrb),
        .bvalid         (bvalid),
        .bready         (bready),
        .bresp          (bresp),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rresp          (rresp)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic bound_fail(input string name);
        n_total++;
        $display("FAIL %s: wait bound expired, got no event expected one", name);
    endtask

    // Slave: readies/valids chosen at negedge, so a handshake happens at the following posedge.
    int          cfg_aw, cfg_w, cfg_b, cfg_ar, cfg_r;
    logic [1:0]  cfg_resp;
    bit          cfg_ovr_en;
    logic [31:0] cfg_ovr;
    logic [31:0] cap_aw, cap_w, cap_ar;
    logic [3:0]  cap_strb;
    int          aw_hi = 0, w_hi = 0, b_hs = 0;
    logic [31:0] smem [logic [31:0]];

    initial begin
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
        rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                aw_hi++;
                if (aw_wait >= cfg_aw) begin awready = 1; cap_aw = awaddr; end
                else begin awready = 0; aw_wait++; end
            end else begin awready = 0; aw_wait = 0; end
            if (wvalid) begin
                w_hi++;
                if (w_wait >= cfg_w) begin wready = 1; cap_w = wdata; cap_strb = wstrb; end
                else begin wready = 0; w_wait++; end
            end else begin wready = 0; w_wait = 0; end
            if (bready) begin
                if (b_wait >= cfg_b) begin
                    bvalid = 1; bresp = cfg_resp; b_hs++; smem[cap_aw] = cap_w;
                end else begin bvalid = 0; b_wait++; end
            end else begin bvalid = 0; b_wait = 0; end
            if (arvalid) begin
                if (ar_wait >= cfg_ar) begin arready = 1; cap_ar = araddr; end
                else begin arready = 0; ar_wait++; end
            end else begin arready = 0; ar_wait = 0; end
            if (rready) begin
                if (r_wait >= cfg_r) begin
                    rvalid = 1; rresp = cfg_resp;
                    if (cfg_ovr_en) rdata = cfg_ovr;
                    else rdata = smem.exists(cap_ar) ? smem[cap_ar] : 32'h0;
                end else begin rvalid = 0; r_wait++; end
            end else begin rvalid = 0; r_wait = 0; end
        end
    end

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        int          aw, w, b, ar, r;
        logic [1:0]  resp;
        bit          ovr_en;
        logic [31:0] ovr;
        int          hold;
        logic [31:0] e_data;
        logic [1:0]  e_resp;
        bit          e_to;
        int          e_lat;
        int          e_aw, e_w, e_b;  // -1 skips channel-activity checks
    } vec_t;

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdat,
                                int aw, int w, int b, int ar, int r, logic [1:0] resp,
                                bit ovr_en, logic [31:0] ovr, int hold,
                                logic [31:0] e_data, logic [1:0] e_resp, bit e_to, int e_lat,
                                int e_aw, int e_w, int e_b);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdat = wdat; v.aw = aw; v.w = w; v.b = b;
        v.ar = ar; v.r = r; v.resp = resp; v.ovr_en = ovr_en; v.ovr = ovr; v.hold = hold;
        v.e_data = e_data; v.e_resp = e_resp; v.e_to = e_to; v.e_lat = e_lat;
        v.e_aw = e_aw; v.e_w = e_w; v.e_b = e_b;
        return v;
    endfunction

    // Timing model: phase-1 delay x, phase-2 delay y, in cycles after the accept cycle.
    function automatic void model_timing(input int x, input int y, output int lat,
                                         output bit to);
        int p1, p2, lim;
        p1 = 1 + x;
        if (p1 > TO) begin lat = TO + 1; to = 1; return; end
        p2  = p1 + 1 + y;
        lim = (p1 + 1 > TO) ? p1 + 1 : TO;
        if (p2 > lim) begin lat = lim + 1; to = 1; end
        else begin lat = p2 + 1; to = 0; end
    endfunction

    task automatic send_cmd(input vec_t v, output int acc, output bit ok);
        int k;
        cfg_aw = v.aw; cfg_w = v.w; cfg_b = v.b; cfg_ar = v.ar; cfg_r = v.r;
        cfg_resp = v.resp; cfg_ovr_en = v.ovr_en; cfg_ovr = v.ovr;
        cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdat;
        k = 0;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        ok = (k < 50);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        int acc, k, aw0, w00, b0;
        bit ok;
        logic [31:0] d0;
        aw0 = aw_hi; w00 = w_hi; b0 = b_hs;
        send_cmd(v, acc, ok);
        if (!ok) begin bound_fail({tag, "_accept"}); return; end
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        if (k >= 100) begin bound_fail({tag, "_rsp"}); return; end
        check({tag, "_lat"}, 64'(cyc - acc), 64'(v.e_lat));
        check({tag, "_data"}, 64'(rsp_data), 64'(v.e_data));
        check({tag, "_resp"}, 64'(rsp_resp), 64'(v.e_resp));
        check({tag, "_timeout"}, 64'(rsp_timeout), 64'(v.e_to));
        d0 = rsp_data;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(rsp_data), 64'(d0));
            check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        check({tag, "_rsp_drop"}, 64'(rsp_valid), 64'd0);
        if (v.e_aw >= 0) begin
            check({tag, "_aw_cycles"}, 64'(aw_hi - aw0), 64'(v.e_aw));
            check({tag, "_w_cycles"}, 64'(w_hi - w00), 64'(v.e_w));
            check({tag, "_b_count"}, 64'(b_hs - b0), 64'(v.e_b));
        end
        if (v.wr && !v.e_to) begin
            check({tag, "_awaddr"}, 64'(cap_aw), 64'(v.addr));
            check({tag, "_wdata"}, 64'(cap_w), 64'(v.wdat));
            check({tag, "_wstrb"}, 64'(cap_strb), 64'hf);
        end
        if (!v.wr && !v.e_to) check({tag, "_araddr"}, 64'(cap_ar), 64'(v.addr));
    endtask

    vec_t tbl[12];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        vec_t v;
        int acc, k, lat;
        bit ok, to;

        //                wr addr       wdata        aw  w  b  ar  r rsp ovr ovr_val     hold
        //                e_data        e_rsp to lat e_aw e_w e_b
        tbl[0]  = mk(1, 32'h508, 32'h1,        0, 0, 0, 0,  0, 0, 0, 0,            0,
                     32'h0,        0, 0, 3,  1,  1, 1);
        tbl[1]  = mk(1, 32'h500, 32'h12345678, 0, 3, 0, 0,  0, 0, 0, 0,            0,
                     32'h0,        0, 0, 6,  1,  4, 1);
        tbl[2]  = mk(0, 32'h500, 32'h0,        0, 0, 0, 0,  0, 0, 1, 32'h78563412, 0,
                     32'h78563412, 0, 0, 3, -1, -1, -1);
        tbl[3]  = mk(0, 32'h50c, 32'h0,        0, 0, 0, 0,  0, 0, 1, 32'hdeaddead, 5,
                     32'hdeaddead, 0, 0, 3, -1, -1, -1);
        tbl[4]  = mk(0, 32'h508, 32'h0,        0, 0, 0, 2,  1, 0, 0, 0,            0,
                     32'h1,        0, 0, 6, -1, -1, -1);
        tbl[5]  = mk(1, 32'h504, 32'ha5,       2, 0, 1, 0,  0, 2, 0, 0,            0,
                     32'h0,        2, 0, 6,  3,  1, 1);
        tbl[6]  = mk(0, 32'h504, 32'h0,        0, 0, 0, 0,  0, 3, 0, 0,            0,
                     32'ha5,       3, 0, 3, -1, -1, -1);
        tbl[7]  = mk(0, 32'h600, 32'h0,        0, 0, 0, 99, 0, 0, 0, 0,            0,
                     32'hdeaddead, 2, 1, 17, -1, -1, -1);
        tbl[8]  = mk(0, 32'h508, 32'h0,        0, 0, 0, 15, 0, 0, 0, 0,            0,
                     32'h1,        0, 0, 18, -1, -1, -1);
        tbl[9]  = mk(1, 32'h50c, 32'h55,       0, 0, 99, 0, 0, 0, 0, 0,            0,
                     32'h0,        2, 1, 17,  1,  1, 0);
        tbl[10] = mk(1, 32'h50c, 32'h66,       99, 0, 0, 0, 0, 0, 0, 0,            0,
                     32'h0,        2, 1, 17, 16,  1, 0);
        tbl[11] = mk(0, 32'h50c, 32'h0,        0, 0, 0, 0,  0, 0, 0, 0,            0,
                     32'h0,        0, 0, 3, -1, -1, -1);

        cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0;
        cfg_resp = 0; cfg_ovr_en = 0; cfg_ovr = 0;
        rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        check("reset_valids", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_fields", 64'({rsp_data, rsp_resp, rsp_timeout}), 64'd0);
        rst_n = 1;
        @(negedge clk);
        check("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int i = 0; i < 12; i++) check_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting in the read-data phase, then a clean read.
        v = mk(0, 32'h504, 32'h0, 0, 0, 0, 0, 99, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1, -1, -1);
        send_cmd(v, acc, ok);
        if (!ok) bound_fail("rstmid_accept");
        k = 0;
        while (!rready && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) bound_fail("rstmid_rready");
        rst_n = 0;
        @(negedge clk);
        check("rstmid_rready", 64'(rready), 64'd0);
        check("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstmid_cmd_ready", 64'(cmd_ready), 64'd0);
        rst_n = 1;
        @(negedge clk);
        check("rstmid_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check_vec(mk(0, 32'h504, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     32'ha5, 0, 0, 3, -1, -1, -1), "after_rst");

        // Randomized traffic against the memory and timing model.
        ref_mem[32'h508] = 32'h1;
        ref_mem[32'h500] = 32'h12345678;
        ref_mem[32'h504] = 32'ha5;
        for (int t = 0; t < 40; t++) begin
            v.wr = 1'($urandom_range(0, 1));
            v.addr = 32'h500 + 32'(4 * $urandom_range(0, 3));
            v.wdat = $urandom;
            v.aw = $urandom_range(0, 9); v.w = $urandom_range(0, 9);
            v.b = $urandom_range(0, 9); v.ar = $urandom_range(0, 9);
            v.r = $urandom_range(0, 9);
            v.resp = 2'($urandom_range(0, 3));
            v.ovr_en = 0; v.ovr = 0;
            v.hold = $urandom_range(0, 2);
            v.e_aw = -1; v.e_w = -1; v.e_b = -1;
            if (v.wr) model_timing((v.aw > v.w) ? v.aw : v.w, v.b, lat, to);
            else model_timing(v.ar, v.r, lat, to);
            v.e_lat = lat;
            v.e_to = to;
            v.e_resp = to ? 2'b10 : v.resp;
            if (v.wr) v.e_data = 32'h0;
            else if (to) v.e_data = 32'hdeaddead;
            else v.e_data = ref_mem.exists(v.addr) ? ref_mem[v.addr] : 32'h0;
            check_vec(v, $sformatf("rnd%0d", t));
            if (v.wr && !to) ref_mem[v.addr] = v.wdat;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
